// File: rtl/bitwise_pkg.sv
// bitwise_pkg: shared op codes and op type for the bitwise stream unit
package bitwise_pkg;
    typedef logic [2:0] op_t;
    localparam op_t OP_AND   = 3'd0;
    localparam op_t OP_OR    = 3'd1;
    localparam op_t OP_XOR   = 3'd2;
    localparam op_t OP_NAND  = 3'd3;
    localparam op_t OP_NOR   = 3'd4;
    localparam op_t OP_XNOR  = 3'd5;
    localparam op_t OP_ACCX  = 3'd6;
    localparam op_t OP_ACCLD = 3'd7;
endpackage

// File: rtl/bitwise_fifo.sv
// bitwise_fifo: registered-full FIFO; ready never looks at the pop side, so there is no bypass
module bitwise_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic push, pop;
    assign push_ready = count < FULL;
    assign pop_valid  = count != '0;
    assign pop_data   = pop_valid ? mem[rd_ptr] : '0;
    assign push       = push_valid && push_ready;
    assign pop        = pop_valid && pop_ready;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= push && !pop ? count + 1'b1 : !push && pop ? count - 1'b1 : count;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/bitwise_stream_unit.sv
// bitwise_stream_unit: streaming bitwise logic unit with XOR accumulator and output FIFO
module bitwise_stream_unit
    import bitwise_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             par
);
    logic [WIDTH-1:0] acc, result;
    logic [WIDTH+1:0] head;
    logic fire;
    always_comb begin
        result = '0;
        case (op)
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_XOR:   result = a ^ b;
            OP_NAND:  result = ~(a & b);
            OP_NOR:   result = ~(a | b);
            OP_XNOR:  result = ~(a ^ b);
            OP_ACCX:  result = acc ^ a;
            default:  result = a;
        endcase
    end
    assign fire = in_valid && in_ready;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) acc <= '0;
        else if (fire && (op == OP_ACCX || op == OP_ACCLD)) acc <= result;
    end
    bitwise_fifo #(.WIDTH(WIDTH + 2), .DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_valid (in_valid),
        .push_ready (in_ready),
        .push_data  ({^result, result == '0, result}),
        .pop_valid  (out_valid),
        .pop_ready  (out_ready),
        .pop_data   (head)
    );
    assign {par, zr, out} = head;
endmodule

// File: tb/tb_bitwise_stream_unit.sv
// tb_bitwise_stream_unit: scoreboard bench; driver queues expected results, negedge monitor checks them
module tb_bitwise_stream_unit;
    logic clk = 0;
    logic reset = 1;
    logic in_valid = 0, out_ready = 0;
    logic [15:0] a = 0, b = 0;
    logic [2:0] op = 0;
    logic in_ready, out_valid, zr, par;
    logic [15:0] out;
    int checks = 0, errors = 0;
    logic [17:0] sb [$];

    bitwise_stream_unit #(.WIDTH(16), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .zr(zr), .par(par)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
        case (o)
            3'd0: return x & y;
            3'd1: return x | y;
            3'd2: return x ^ y;
            3'd3: return ~(x & y);
            3'd4: return ~(x | y);
            default: return ~(x ^ y);
        endcase
    endfunction

    function automatic logic [17:0] pack(input logic [15:0] r);
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(r[i]);
        return {n[0], r == 16'h0, r};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y, input logic [17:0] exp);
        int t = 0;
        in_valid = 1; op = o; a = x; b = y;
        while (!in_ready) begin
            if (++t > 200) begin
                chk("send_timeout", 0, 1);
                break;
            end
            step();
        end
        sb.push_back(exp);
        step();
        in_valid = 0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("unexpected_output", {14'h0, par, zr, out}, 32'hdead);
                else chk("head", {14'h0, par, zr, out}, {14'h0, sb.pop_front()});
            end else if (!out_valid) begin
                chk("idle_zero", {14'h0, par, zr, out}, 0);
            end
        end
    end

    initial begin
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out, 0);
        step(); step();
        reset = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle", {in_ready, out_valid, out}, {2'b10, 16'h0});
        end
        out_ready = 1;
        send(3'd2, 16'hF0F0, 16'h0FF0, {1'b0, 1'b0, 16'hFF00});
        send(3'd0, 16'hFFFF, 16'h0000, {1'b0, 1'b1, 16'h0000});
        send(3'd5, 16'h0F0F, 16'h0F0E, {1'b1, 1'b0, 16'hFFFE});
        for (int i = 0; i < 10000; i++) begin
            logic [2:0] ro = 3'($urandom_range(0, 5));
            logic [15:0] ra = 16'($urandom), rb = 16'($urandom);
            send(ro, ra, rb, pack(ref_op(ro, ra, rb)));
        end
        send(3'd7, 16'h1234, 16'h0, {1'b1, 1'b0, 16'h1234});
        send(3'd6, 16'h00FF, 16'hFFFF, {1'b1, 1'b0, 16'h12CB});
        send(3'd6, 16'h12CB, 16'h0, {1'b0, 1'b1, 16'h0000});
        step();
        out_ready = 0;
        send(3'd0, 16'hFFFF, 16'h00FF, {1'b0, 1'b0, 16'h00FF});
        send(3'd1, 16'h0F00, 16'h0001, {1'b1, 1'b0, 16'h0F01});
        in_valid = 1; op = 3'd2; a = 16'hAAAA; b = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            chk("bp_full_in_ready", in_ready, 0);
            chk("bp_hold", {out_valid, out}, {1'b1, 16'h00FF});
            step();
        end
        out_ready = 1;
        chk("bp_pop_cycle_in_ready", in_ready, 0);
        step();
        chk("bp_after_pop_in_ready", in_ready, 1);
        sb.push_back({1'b0, 1'b0, 16'hFFFF});
        step();
        in_valid = 0;
        for (int i = 0; i < 4; i++) step();
        chk("bp_drained", sb.size(), 0);
        out_ready = 0;
        send(3'd1, 16'h0001, 16'h0100, {1'b0, 1'b0, 16'h0101});
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            logic [15:0] ra = 16'(i * 16'h1111 + 3), rb = 16'(16'h00F0 << i);
            chk("pp_count1", {out_valid, in_ready}, 2'b11);
            in_valid = 1; op = 3'd2; a = ra; b = rb;
            sb.push_back(pack(ra ^ rb));
            step();
        end
        in_valid = 0;
        for (int i = 0; i < 4; i++) step();
        chk("pp_drained", sb.size(), 0);
        chk("pp_empty", out_valid, 0);
        out_ready = 0;
        send(3'd7, 16'h5555, 16'h0, {1'b0, 1'b0, 16'h5555});
        send(3'd6, 16'h0F0F, 16'h0, {1'b0, 1'b0, 16'h5A5A});
        chk("pre_reset_full", {out_valid, in_ready}, 2'b10);
        reset = 1;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out", {par, zr, out}, 0);
        chk("reset_in_ready", in_ready, 1);
        sb.delete();
        step(); step();
        reset = 0;
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_reset_quiet", out_valid, 0);
        end
        send(3'd6, 16'h0001, 16'h0, {1'b1, 1'b0, 16'h0001});
        for (int i = 0; i < 200 && sb.size() != 0; i++) step();
        step();
        chk("final_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bitwise_stream_unit.md
# bitwise_stream_unit

Parametrised, streaming successor to the 16-bit combinational Xor16 gate: a WIDTH-bit bitwise logic unit with selectable operation, a running XOR accumulator, and an output FIFO with valid/ready flow control on both sides. It sits between an operand producer, such as a register file or a RAM read port, and a consumer that may stall, such as the ALU or the writeback path. Each accepted operand pair yields exactly one result word with zero and parity flags, in order.

## Interface
- `WIDTH`, 16, operand/result width in bits (≥1)
- `DEPTH`, 2, output FIFO entries (power of two, ≥2)
- `clk`  in  1  single clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  operand pair present
- `in_ready`  out  1  unit can accept this cycle
- `a`, `b`  in  WIDTH  operands
- `op`  in  3  operation select, sampled with the operands
- `out_valid`  out  1  FIFO head valid
- `out_ready`  in  1  consumer takes the head this cycle
- `out`  out  WIDTH  result at the FIFO head
- `zr`  out  1  head result == 0
- `par`  out  1  XOR-reduction of the head result

## Operation
- The handshake fires on a side when valid && ready on the same rising edge. Valid must not depend combinationally on ready.
- `op` encoding:
  - 0 AND: a&b
  - 1 OR: a|b
  - 2 XOR: a^b
  - 3 NAND
  - 4 NOR
  - 5 XNOR
  - 6 ACCX: result = acc^a; acc ← result; `b` ignored
  - 7 ACCLD: result = a; acc ← a
- `acc` is a WIDTH-bit internal register. It updates only on an accepted op 6 or 7. Ops 0–5 leave it unchanged.
- The result and its flags are computed on acceptance and pushed into the FIFO together.
- `in_ready` = FIFO count < DEPTH. It is derived from registered state only.
- A pop occurs when out_valid && out_ready.
- Push and pop in the same cycle are allowed when 0 < count ≤ DEPTH−1: count is unchanged and data stays in order.
- When the FIFO is full, `in_ready` is 0 even if a pop occurs that cycle. There is no bypass. The freed slot is visible as `in_ready` = 1 on the next cycle.
- Empty FIFO: `out_valid` = 0. `out`, `zr` and `par` are 0.
- Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- All arithmetic is pure bitwise. No carries, no width growth.

## Timing
- Reset (asynchronous assert, release synchronised by the system):
  - `acc` = 0, count = 0, pointers = 0
  - `out_valid` = 0, `out`/`zr`/`par` = 0
  - `in_ready` = 1
- Latency: an operand accepted at edge N is at the head with `out_valid` = 1 after edge N when the FIFO was empty.
- Throughput: 1 result per cycle while `out_ready` is held at 1.
- Stall: head data and flags hold stable while out_valid && !out_ready.
- Reset mid-stream: all queued results are discarded and `acc` clears. Nothing is emitted after reset until a new acceptance.
- ACCX back-to-back: the second op in consecutive cycles uses the `acc` value written by the first.

## Structure
- Shared package `bitwise_pkg`:
  - op codes as localparams (`OP_AND` … `OP_ACCLD`)
  - the 3-bit op typedef
- One sub-module, `bitwise_fifo`. It is parametrised by WIDTH+2 and DEPTH and stores {par, zr, result}. The top level holds the op decoder, `acc`, and the flag computation.

## Test plan
- Reset, then idle: `in_ready` = 1, `out_valid` = 0, `out` = 0 → stays so for 10 cycles.
- Stream test, `out_ready` = 1: 10000 random pairs with random op 0–5, compared against a per-op reference model (XOR must be a^b, not a&b). Also check a=16'hF0F0, b=16'h0FF0, op 2 → out=16'hFF00, zr=0, par=0.
- Accumulator sequence:
  - ACCLD a=16'h1234 → out 16'h1234
  - ACCX a=16'h00FF → 16'h12CB
  - ACCX a=16'h12CB → 16'h0000, zr=1, par=0
- Backpressure: `out_ready` = 0 with 3 pushes attempted → only DEPTH=2 accepted and `in_ready` = 0. Raise `out_ready` → the 2 results come out in order and `in_ready` returns the cycle after the first pop.
- Simultaneous push/pop at count 1 for 8 cycles → count stays 1, no loss, no duplication.
- Assert `reset` mid-burst with 2 results queued and acc ≠ 0 → `out_valid` drops immediately. Then ACCX a=16'h0001 → out 16'h0001.
